// File: rtl/uart_fifo_port.sv
`default_nettype none
// ============================================================================
//  Module   : uart_fifo_port
//  Brief    : UART transmitter/receiver with a FIFO on each side, configurable
//             word width, parity and stop bits. The bit divisor is CLK_FREQ/BAUD.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_fifo_port #(
    parameter  int CLK_FREQ   = 90_000_000,
    parameter  int BAUD       = 1_152_000,
    parameter  int DATA_BITS  = 8,
    parameter  int PARITY     = 0,
    parameter  int STOP_BITS  = 1,
    parameter  int FIFO_DEPTH = 16,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic                 txd,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    input  logic                 ovr_clr,
    output logic [CW-1:0]        tx_count,
    output logic [CW-1:0]        rx_count
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int TW  = $clog2(STOP_BITS * DIV + 1);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int RW  = DATA_BITS + 2;

    localparam logic [TW-1:0] c_DIV_M1  = TW'(DIV - 1);
    localparam logic [TW-1:0] c_HALF_M1 = TW'(DIV / 2 - 1);
    localparam logic [TW-1:0] c_STOP_M1 = TW'(STOP_BITS * DIV - 1);
    localparam logic [BW-1:0] c_LAST    = BW'(DATA_BITS - 1);
    localparam logic [CW-1:0] c_FULL    = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_tx_wp;
    logic [AW-1:0]        r_tx_rp;
    logic [CW-1:0]        r_tx_count;
    logic                 w_tx_push;
    logic                 w_tx_pop;
    logic [DATA_BITS-1:0] w_tx_head;
    logic                 w_tx_head_par;

    assign tx_ready      = (r_tx_count != c_FULL);
    assign tx_count      = r_tx_count;
    assign w_tx_push     = tx_valid && tx_ready;
    assign w_tx_head     = r_tx_mem[r_tx_rp];
    assign w_tx_head_par = (PARITY == 1) ? ~^w_tx_head : ^w_tx_head;

    // TX FIFO storage write
    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wp] <= tx_data;
        end
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wp    <= '0;
            r_tx_rp    <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + AW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + AW'(1);
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + CW'(1);
                2'b01:   r_tx_count <= r_tx_count - CW'(1);
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX engine
    // ------------------------------------------------------------------
    state_t               r_tx_state, w_tx_state_nxt;
    logic [TW-1:0]        r_tx_cnt, w_tx_cnt_nxt;
    logic [BW-1:0]        r_tx_bit, w_tx_bit_nxt;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
    logic                 r_tx_par, w_tx_par_nxt;
    logic                 r_txd, w_txd_nxt;

    assign txd = r_txd;

    // TX state and datapath registers; txd comes straight from a flop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_par   <= w_tx_par_nxt;
            r_txd      <= w_txd_nxt;
        end
    end

    // TX next-state: the txd value for the next bit is decided here
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + TW'(1);
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_par_nxt   = r_tx_par;
        w_txd_nxt      = r_txd;
        w_tx_pop       = 1'b0;
        case (r_tx_state)
            S_IDLE: begin
                w_tx_cnt_nxt = '0;
                w_txd_nxt    = 1'b1;
                if (r_tx_count != '0) begin
                    w_tx_pop       = 1'b1;
                    w_tx_shift_nxt = w_tx_head;
                    w_tx_par_nxt   = w_tx_head_par;
                    w_tx_state_nxt = S_START;
                    w_txd_nxt      = 1'b0;
                end
            end
            S_START: begin
                if (r_tx_cnt == c_DIV_M1) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_bit_nxt   = '0;
                    w_tx_state_nxt = S_DATA;
                    w_txd_nxt      = r_tx_shift[0];
                end
            end
            S_DATA: begin
                if (r_tx_cnt == c_DIV_M1) begin
                    w_tx_cnt_nxt = '0;
                    if (r_tx_bit == c_LAST) begin
                        if (PARITY != 0) begin
                            w_tx_state_nxt = S_PAR;
                            w_txd_nxt      = r_tx_par;
                        end else begin
                            w_tx_state_nxt = S_STOP;
                            w_txd_nxt      = 1'b1;
                        end
                    end else begin
                        w_tx_bit_nxt   = r_tx_bit + BW'(1);
                        w_tx_shift_nxt = r_tx_shift >> 1;
                        w_txd_nxt      = r_tx_shift[1];
                    end
                end
            end
            S_PAR: begin
                if (r_tx_cnt == c_DIV_M1) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_state_nxt = S_STOP;
                    w_txd_nxt      = 1'b1;
                end
            end
            S_STOP: begin
                if (r_tx_cnt == c_STOP_M1) begin
                    w_tx_cnt_nxt = '0;
                    // Chain straight into the next start bit when work is queued
                    if (r_tx_count != '0) begin
                        w_tx_pop       = 1'b1;
                        w_tx_shift_nxt = w_tx_head;
                        w_tx_par_nxt   = w_tx_head_par;
                        w_tx_state_nxt = S_START;
                        w_txd_nxt      = 1'b0;
                    end else begin
                        w_tx_state_nxt = S_IDLE;
                        w_txd_nxt      = 1'b1;
                    end
                end
            end
            default: begin
                w_tx_state_nxt = S_IDLE;
                w_tx_cnt_nxt   = '0;
                w_txd_nxt      = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RX synchroniser and engine
    // ------------------------------------------------------------------
    logic                 r_rx_s1, r_rx_s2, r_rx_s3;
    state_t               r_rx_state, w_rx_state_nxt;
    logic [TW-1:0]        r_rx_cnt, w_rx_cnt_nxt;
    logic [BW-1:0]        r_rx_bit, w_rx_bit_nxt;
    logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_nxt;
    logic                 r_rx_par, w_rx_par_nxt;
    logic                 w_rx_push;
    logic [RW-1:0]        w_rx_word;
    logic                 w_rx_exp_par;

    assign w_rx_exp_par = (PARITY == 1) ? ~^r_rx_shift : ^r_rx_shift;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= rxd;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    // RX state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_bit   <= w_rx_bit_nxt;
            r_rx_shift <= w_rx_shift_nxt;
            r_rx_par   <= w_rx_par_nxt;
        end
    end

    // RX next-state: sample at the start-bit midpoint, then every DIV cycles
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_cnt_nxt   = r_rx_cnt + TW'(1);
        w_rx_bit_nxt   = r_rx_bit;
        w_rx_shift_nxt = r_rx_shift;
        w_rx_par_nxt   = r_rx_par;
        w_rx_push      = 1'b0;
        w_rx_word      = {1'b0, 1'b0, r_rx_shift};
        case (r_rx_state)
            S_IDLE: begin
                w_rx_cnt_nxt = '0;
                if (r_rx_s3 && !r_rx_s2) begin
                    w_rx_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_rx_cnt == c_HALF_M1) begin
                    w_rx_cnt_nxt = '0;
                    w_rx_bit_nxt = '0;
                    // A line already back high is a glitch, not a start bit
                    w_rx_state_nxt = r_rx_s2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_rx_cnt == c_DIV_M1) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_shift_nxt = {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_bit == c_LAST) begin
                        w_rx_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        w_rx_bit_nxt = r_rx_bit + BW'(1);
                    end
                end
            end
            S_PAR: begin
                if (r_rx_cnt == c_DIV_M1) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_par_nxt   = r_rx_s2;
                    w_rx_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (r_rx_cnt == c_DIV_M1) begin
                    w_rx_cnt_nxt   = '0;
                    w_rx_push      = 1'b1;
                    w_rx_word      = {!r_rx_s2,
                                      (PARITY != 0) && (r_rx_par != w_rx_exp_par),
                                      r_rx_shift};
                    w_rx_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_rx_state_nxt = S_IDLE;
                w_rx_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RX FIFO: entry = {frame_err, parity_err, data}
    // ------------------------------------------------------------------
    logic [RW-1:0] r_rx_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rx_wp;
    logic [AW-1:0] r_rx_rp;
    logic [CW-1:0] r_rx_count;
    logic          r_rx_ovr;
    logic          w_rx_full;
    logic          w_rx_pop;
    logic          w_rx_wr;
    logic          w_rx_ovr_evt;
    logic [RW-1:0] w_rx_head;

    assign w_rx_full    = (r_rx_count == c_FULL);
    assign w_rx_pop     = rx_valid && rx_ready;
    assign w_rx_wr      = w_rx_push && (!w_rx_full || w_rx_pop);
    assign w_rx_ovr_evt = w_rx_push && w_rx_full && !w_rx_pop;
    assign w_rx_head    = r_rx_mem[r_rx_rp];

    assign rx_valid      = (r_rx_count != '0);
    assign rx_data       = rx_valid ? w_rx_head[DATA_BITS-1:0] : '0;
    assign rx_parity_err = rx_valid && w_rx_head[DATA_BITS];
    assign rx_frame_err  = rx_valid && w_rx_head[DATA_BITS+1];
    assign rx_overrun    = r_rx_ovr;
    assign rx_count      = r_rx_count;

    // RX FIFO storage write
    always_ff @(posedge clk) begin
        if (w_rx_wr) begin
            r_rx_mem[r_rx_wp] <= w_rx_word;
        end
    end

    // RX FIFO pointers, occupancy and sticky overrun (set beats clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_wp    <= '0;
            r_rx_rp    <= '0;
            r_rx_count <= '0;
            r_rx_ovr   <= 1'b0;
        end else begin
            if (w_rx_wr)  r_rx_wp <= r_rx_wp + AW'(1);
            if (w_rx_pop) r_rx_rp <= r_rx_rp + AW'(1);
            case ({w_rx_wr, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + CW'(1);
                2'b01:   r_rx_count <= r_rx_count - CW'(1);
                default: r_rx_count <= r_rx_count;
            endcase
            if (w_rx_ovr_evt) begin
                r_rx_ovr <= 1'b1;
            end else if (ovr_clr) begin
                r_rx_ovr <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_fifo_port
//  Brief    : Directed self-checking bench for uart_fifo_port, DIV=8, depth 4.
//             u_even runs PARITY=2 (TX, loopback, overrun); u_odd runs
//             PARITY=1 (frame/parity errors, false start).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_port;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic line;
    logic loop_en;

    // even-parity instance
    logic       tx_valid_e, tx_ready_e, txd_e, rxd_e;
    logic [7:0] tx_data_e, rx_data_e;
    logic       rx_valid_e, rx_ready_e, perr_e, ferr_e, ovr_e, ovr_clr_e;
    logic [2:0] tx_count_e, rx_count_e;

    // odd-parity instance
    logic       tx_valid_o, tx_ready_o, txd_o;
    logic [7:0] tx_data_o, rx_data_o;
    logic       rx_valid_o, rx_ready_o, perr_o, ferr_o, ovr_o, ovr_clr_o;
    logic [2:0] tx_count_o, rx_count_o;

    assign rxd_e = loop_en ? txd_e : line;

    uart_fifo_port #(
        .CLK_FREQ(8_000_000), .BAUD(1_000_000), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_even (
        .clk(clk), .rst(rst), .rxd(rxd_e), .txd(txd_e),
        .tx_valid(tx_valid_e), .tx_data(tx_data_e), .tx_ready(tx_ready_e),
        .rx_valid(rx_valid_e), .rx_data(rx_data_e), .rx_ready(rx_ready_e),
        .rx_parity_err(perr_e), .rx_frame_err(ferr_e),
        .rx_overrun(ovr_e), .ovr_clr(ovr_clr_e),
        .tx_count(tx_count_e), .rx_count(rx_count_e)
    );

    uart_fifo_port #(
        .CLK_FREQ(8_000_000), .BAUD(1_000_000), .DATA_BITS(8),
        .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_odd (
        .clk(clk), .rst(rst), .rxd(line), .txd(txd_o),
        .tx_valid(tx_valid_o), .tx_data(tx_data_o), .tx_ready(tx_ready_o),
        .rx_valid(rx_valid_o), .rx_data(rx_data_o), .rx_ready(rx_ready_o),
        .rx_parity_err(perr_o), .rx_frame_err(ferr_o),
        .rx_overrun(ovr_o), .ovr_clr(ovr_clr_o),
        .tx_count(tx_count_o), .rx_count(rx_count_o)
    );

    int vecs = 0;
    int errs = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance n clocks and land 1 time unit after the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // start, 8 data LSB first, even parity, stop; index 0 is the start bit
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        return {1'b1, ^d, d, 1'b0};
    endfunction

    task automatic push_e(input logic [7:0] d);
        tx_valid_e = 1'b1;
        tx_data_e  = d;
        tick(1);
        tx_valid_e = 1'b0;
    endtask

    task automatic find_start(input int budget, input string tag);
        int k = 0;
        while (txd_e !== 1'b0 && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, {31'd0, txd_e}, 32'd0);
    endtask

    task automatic check_tx_frame(input logic [7:0] d, input string tag);
        logic [10:0] fb;
        fb = frame_bits(d);
        for (int c = 0; c < 88; c++) begin
            check(tag, {31'd0, txd_e}, {31'd0, fb[c/8]});
            tick(1);
        end
    endtask

    task automatic wait_rx_e(input int budget, input string tag);
        int k = 0;
        while (rx_valid_e !== 1'b1 && k < budget) begin
            tick(1);
            k++;
        end
        check(tag, {31'd0, rx_valid_e}, 32'd1);
    endtask

    // drive one serial frame on the shared bench line, then idle 16 cycles
    task automatic send(input logic [7:0] d, input bit use_par, input bit pbit, input bit stopv);
        line = 1'b0;
        tick(8);
        for (int i = 0; i < 8; i++) begin
            line = d[i];
            tick(8);
        end
        if (use_par) begin
            line = pbit;
            tick(8);
        end
        line = stopv;
        tick(8);
        line = 1'b1;
        tick(16);
    endtask

    task automatic pop_e();
        rx_ready_e = 1'b1;
        tick(1);
        rx_ready_e = 1'b0;
    endtask

    task automatic pop_o();
        rx_ready_o = 1'b1;
        tick(1);
        rx_ready_o = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
    endtask

    logic [7:0] ovr_words [5];

    initial begin
        rst        = 1'b1;
        line       = 1'b1;
        loop_en    = 1'b0;
        tx_valid_e = 1'b0; tx_data_e = 8'h00; rx_ready_e = 1'b0; ovr_clr_e = 1'b0;
        tx_valid_o = 1'b0; tx_data_o = 8'h00; rx_ready_o = 1'b0; ovr_clr_o = 1'b0;
        ovr_words[0] = 8'h11; ovr_words[1] = 8'h22; ovr_words[2] = 8'h33;
        ovr_words[3] = 8'h44; ovr_words[4] = 8'h55;

        // ---- reset state ----
        tick(3);
        check("rst_txd",      {31'd0, txd_e},      32'd1);
        check("rst_tx_ready", {31'd0, tx_ready_e}, 32'd1);
        check("rst_rx_valid", {31'd0, rx_valid_e}, 32'd0);
        check("rst_rx_data",  {24'd0, rx_data_e},  32'd0);
        check("rst_tx_count", {29'd0, tx_count_e}, 32'd0);
        check("rst_rx_count", {29'd0, rx_count_e}, 32'd0);
        check("rst_overrun",  {31'd0, ovr_e},      32'd0);
        check("rst_perr",     {31'd0, perr_e},     32'd0);
        check("rst_ferr",     {31'd0, ferr_e},     32'd0);
        rst = 1'b0;
        tick(1);
        check("post_rst_txd", {31'd0, txd_e}, 32'd1);

        // ---- single TX frame, 0xA5 even parity ----
        push_e(8'hA5);
        find_start(2, "tx_a5_start_latency");
        check_tx_frame(8'hA5, "tx_a5_bit");
        check("tx_a5_idle_after", {31'd0, txd_e}, 32'd1);
        check("tx_a5_count",      {29'd0, tx_count_e}, 32'd0);

        // ---- back-to-back frames ----
        tick(5);
        tx_valid_e = 1'b1; tx_data_e = 8'h12;
        tick(1);
        tx_data_e = 8'h34;
        tick(1);
        tx_valid_e = 1'b0;
        find_start(2, "tx_b2b_start_latency");
        check_tx_frame(8'h12, "tx_b2b_first_bit");
        check_tx_frame(8'h34, "tx_b2b_second_bit");
        check("tx_b2b_idle_after", {31'd0, txd_e}, 32'd1);

        // ---- fill TX FIFO, pushes while full are ignored ----
        tick(5);
        tx_valid_e = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tx_data_e = 8'(i + 1);
            tick(1);
        end
        check("tx_full_count", {29'd0, tx_count_e}, 32'd4);
        check("tx_full_ready", {31'd0, tx_ready_e}, 32'd0);
        check("tx_full_txd_start", {31'd0, txd_e}, 32'd0);
        tx_valid_e = 1'b0;

        // ---- reset in the middle of a start bit ----
        rst = 1'b1;
        tick(1);
        check("midrst_txd",      {31'd0, txd_e},      32'd1);
        check("midrst_tx_count", {29'd0, tx_count_e}, 32'd0);
        check("midrst_tx_ready", {31'd0, tx_ready_e}, 32'd1);
        tick(2);
        rst = 1'b0;
        tick(4);
        check("midrst_txd_idle", {31'd0, txd_e}, 32'd1);

        // ---- loopback 0x3C ----
        loop_en = 1'b1;
        push_e(8'h3C);
        wait_rx_e(200, "loop_rx_valid");
        check("loop_rx_data",  {24'd0, rx_data_e},  32'h3C);
        check("loop_perr",     {31'd0, perr_e},     32'd0);
        check("loop_ferr",     {31'd0, ferr_e},     32'd0);
        check("loop_rx_count", {29'd0, rx_count_e}, 32'd1);
        pop_e();
        check("loop_pop_count", {29'd0, rx_count_e}, 32'd0);
        check("loop_pop_valid", {31'd0, rx_valid_e}, 32'd0);
        tick(20);
        loop_en = 1'b0;

        // ---- odd parity instance: frame error then parity error ----
        do_reset();
        send(8'h55, 1'b1, 1'b1, 1'b0);
        check("ferr_valid", {31'd0, rx_valid_o}, 32'd1);
        check("ferr_data",  {24'd0, rx_data_o},  32'h55);
        check("ferr_flag",  {31'd0, ferr_o},     32'd1);
        check("ferr_perr",  {31'd0, perr_o},     32'd0);
        pop_o();
        check("ferr_pop_count", {29'd0, rx_count_o}, 32'd0);
        send(8'h55, 1'b1, 1'b0, 1'b1);
        check("perr_valid", {31'd0, rx_valid_o}, 32'd1);
        check("perr_data",  {24'd0, rx_data_o},  32'h55);
        check("perr_flag",  {31'd0, perr_o},     32'd1);
        check("perr_ferr",  {31'd0, ferr_o},     32'd0);
        pop_o();

        // ---- overrun: five frames, nobody popping ----
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(ovr_words[i], 1'b1, ^ovr_words[i], 1'b1);
        end
        check("ovr_rx_count", {29'd0, rx_count_e}, 32'd4);
        check("ovr_flag",     {31'd0, ovr_e},      32'd1);
        for (int i = 0; i < 4; i++) begin
            check("ovr_word",      {24'd0, rx_data_e}, {24'd0, ovr_words[i]});
            check("ovr_word_perr", {31'd0, perr_e},    32'd0);
            check("ovr_word_ferr", {31'd0, ferr_e},    32'd0);
            pop_e();
        end
        check("ovr_drained", {29'd0, rx_count_e}, 32'd0);
        check("ovr_sticky",  {31'd0, ovr_e},      32'd1);
        ovr_clr_e = 1'b1;
        tick(1);
        ovr_clr_e = 1'b0;
        check("ovr_cleared", {31'd0, ovr_e}, 32'd0);

        // ---- false start glitch, then a good frame ----
        do_reset();
        line = 1'b0;
        tick(2);
        line = 1'b1;
        tick(20);
        check("glitch_rx_count", {29'd0, rx_count_o}, 32'd0);
        check("glitch_rx_valid", {31'd0, rx_valid_o}, 32'd0);
        send(8'hA3, 1'b1, ~^8'hA3, 1'b1);
        check("after_glitch_valid", {31'd0, rx_valid_o}, 32'd1);
        check("after_glitch_data",  {24'd0, rx_data_o},  32'hA3);
        check("after_glitch_perr",  {31'd0, perr_o},     32'd0);
        check("after_glitch_ferr",  {31'd0, ferr_o},     32'd0);
        check("after_glitch_count", {29'd0, rx_count_o}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
